div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: sequential unsigned divider by repeated subtraction.
// A small FSM drives a shared add/sub datapath (regs A/B, ALU z = A-B or A+B).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - division request (ignored while busy)
//   dividend, divisor   - N-bit unsigned operands, sampled with start
//   busy                - high while a division is in progress
//   valid               - one-cycle pulse, quot/rem updated
//   err                 - one-cycle pulse, request rejected
//   quot, rem           - registered quotient and remainder

// Add/sub Mealy datapath: A/B registers with input muxes and a shared ALU.
module addsub_dp #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         mux1ctl,
    input  logic         mux2ctl,
    input  logic         aluctl,
    input  logic         en_a,
    input  logic         en_b,
    output logic [N-1:0] z
);

    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] a_d;
    logic [N-1:0] b_d;

    // ALU and register input muxes
    always_comb begin
        z   = aluctl ? (a_q - b_q) : (a_q + b_q);
        a_d = mux1ctl ? z : x;
        b_d = mux2ctl ? z : y;
    end

    // Operand registers carry no reset; every accepted start reloads both.
    always_ff @(posedge clk) begin
        if (en_a) a_q <= a_d;
        if (en_b) b_q <= b_d;
    end

endmodule

module div_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         valid,
    output logic         err,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CLRB = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_d;
    logic [N-1:0] qcnt;
    logic [N-1:0] qcnt_d;
    logic [N-1:0] quot_d;
    logic [N-1:0] rem_d;
    logic         valid_d;
    logic         err_d;
    logic         busy_d;

    logic         mux1ctl;
    logic         mux2ctl;
    logic         aluctl;
    logic         en_a;
    logic         en_b;
    logic [N-1:0] dp_y;
    logic [N-1:0] z;
    logic         operands_ok;

    // Operands must have clear MSBs so z[N-1] of A-B is a valid A>=B flag.
    assign operands_ok = (divisor != '0) && !dividend[N-1] && !divisor[N-1];

    // B is cleared through y in CLRB so FIN reads the remainder as A+0.
    assign dp_y = (state == CLRB) ? '0 : divisor;

    addsub_dp #(.N(N)) u_dp (
        .clk     (clk),
        .x       (dividend),
        .y       (dp_y),
        .mux1ctl (mux1ctl),
        .mux2ctl (mux2ctl),
        .aluctl  (aluctl),
        .en_a    (en_a),
        .en_b    (en_b),
        .z       (z)
    );

    // Next-state, next-output and datapath control
    always_comb begin
        state_d = state;
        qcnt_d  = qcnt;
        quot_d  = quot;
        rem_d   = rem;
        valid_d = 1'b0;
        err_d   = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        mux1ctl = 1'b0;
        mux2ctl = 1'b0;
        aluctl  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (operands_ok) begin
                        en_a    = 1'b1;
                        en_b    = 1'b1;
                        qcnt_d  = '0;
                        state_d = SUB;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SUB: begin
                aluctl = 1'b1;
                if (!z[N-1]) begin
                    en_a    = 1'b1;
                    mux1ctl = 1'b1;
                    qcnt_d  = qcnt + N'(1);
                end else begin
                    state_d = CLRB;
                end
            end
            CLRB: begin
                en_b    = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                rem_d   = z;
                quot_d  = qcnt;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            qcnt  <= '0;
            quot  <= '0;
            rem   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            qcnt  <= qcnt_d;
            quot  <= quot_d;
            rem   <= rem_d;
            valid <= valid_d;
            err   <= err_d;
            busy  <= busy_d;
        end
    end

endmodule
